// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results and RV32I loads into the register file,
// aligning load data, flagging misaligned/illegal loads and bus errors.
module writeback_stage #(
  parameter  int BitWidth    = 32,
  parameter  int NumReg      = 32,
  localparam int RegSelWidth = $clog2(NumReg)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RegSelWidth-1:0] in_rd,
  input  logic [BitWidth-1:0]    in_result,
  input  logic                   in_is_load,
  input  logic [2:0]             in_funct3,
  input  logic [1:0]             in_byte_off,
  input  logic                   mem_rsp_valid,
  input  logic [31:0]            mem_rsp_data,
  input  logic                   mem_rsp_err,
  output logic [BitWidth-1:0]    write_data,
  output logic [RegSelWidth-1:0] write_dest,
  output logic                   write_en,
  output logic                   fwd_valid,
  output logic [RegSelWidth-1:0] fwd_rd,
  output logic [BitWidth-1:0]    fwd_data,
  output logic                   load_pending,
  output logic [RegSelWidth-1:0] load_pending_rd,
  output logic                   load_fault,
  output logic [31:0]            retired
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [BitWidth-1:0]    write_data_reg;
  logic [RegSelWidth-1:0] write_dest_reg;
  logic [RegSelWidth-1:0] pend_rd_reg;
  logic [2:0]             pend_f3_reg;
  logic [1:0]             pend_off_reg;
  logic [31:0]            retired_reg;

  logic                   load_legal;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [BitWidth-1:0]    load_data;

  // Legality of the load being presented: reserved funct3 or misaligned access faults.
  always_comb begin
    load_legal = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: load_legal = 1'b1;
      3'b001, 3'b101: load_legal = ~in_byte_off[0];
      3'b010:         load_legal = (in_byte_off == 2'b00);
      default:        load_legal = 1'b0;
    endcase
  end

  // Extract and extend the addressed lane of the word-aligned response.
  always_comb begin
    byte_sel = mem_rsp_data[7:0];
    case (pend_off_reg)
      2'd0: byte_sel = mem_rsp_data[7:0];
      2'd1: byte_sel = mem_rsp_data[15:8];
      2'd2: byte_sel = mem_rsp_data[23:16];
      2'd3: byte_sel = mem_rsp_data[31:24];
      default: byte_sel = mem_rsp_data[7:0];
    endcase
    half_sel = pend_off_reg[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (pend_f3_reg)
      3'b000:  load_data = BitWidth'($signed(byte_sel));
      3'b100:  load_data = BitWidth'(byte_sel);
      3'b001:  load_data = BitWidth'($signed(half_sel));
      3'b101:  load_data = BitWidth'(half_sel);
      default: load_data = BitWidth'(mem_rsp_data);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!in_is_load)     state_next = COMMIT;
          else if (load_legal) state_next = WAIT_MEM;
          else                 state_next = FAULT;
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid) state_next = mem_rsp_err ? FAULT : COMMIT;
      end
      COMMIT:  state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write port registers only move on the edge that enters COMMIT, so they
  // are stable around every write_en pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_data_reg <= '0;
      write_dest_reg <= '0;
      pend_rd_reg    <= '0;
      pend_f3_reg    <= '0;
      pend_off_reg   <= '0;
      retired_reg    <= '0;
    end else begin
      if (state_reg == IDLE && in_valid) begin
        if (!in_is_load) begin
          write_data_reg <= in_result;
          write_dest_reg <= in_rd;
        end else begin
          pend_rd_reg  <= in_rd;
          pend_f3_reg  <= in_funct3;
          pend_off_reg <= in_byte_off;
        end
      end
      if (state_reg == WAIT_MEM && mem_rsp_valid && !mem_rsp_err) begin
        write_data_reg <= load_data;
        write_dest_reg <= pend_rd_reg;
      end
      if (state_reg == COMMIT) begin
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  always_comb begin
    in_ready        = (state_reg == IDLE);
    write_en        = (state_reg == COMMIT) && (write_dest_reg != '0);
    fwd_valid       = write_en;
    load_pending    = (state_reg == WAIT_MEM);
    load_pending_rd = (state_reg == WAIT_MEM) ? pend_rd_reg : '0;
    load_fault      = (state_reg == FAULT);
  end

  assign write_data = write_data_reg;
  assign write_dest = write_dest_reg;
  assign fwd_rd     = write_dest_reg;
  assign fwd_data   = write_data_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: transaction-level scoreboard checked every
// cycle, plus literal expectations at the directed scenario points.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_result = '0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_byte_off = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic [31:0] write_data;
  logic [4:0]  write_dest;
  logic        write_en;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        load_pending;
  logic [4:0]  load_pending_rd;
  logic        load_fault;
  logic [31:0] retired;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_result(in_result),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_byte_off(in_byte_off),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .write_data(write_data), .write_dest(write_dest), .write_en(write_en),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .load_pending(load_pending), .load_pending_rd(load_pending_rd),
    .load_fault(load_fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  ev_t         sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_retired = '0;
  bit          model_pending = 1'b0;
  logic [4:0]  model_pend_rd = '0;
  logic [2:0]  model_f3 = '0;
  logic [1:0]  model_off = '0;
  logic [4:0]  model_load_rd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Load result from the RV32I rules, using plain shifts and arithmetic.
  function automatic logic [31:0] align_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    longint b, h, v;
    b = longint'((w >> (8 * off)) & 32'hFF);
    h = longint'((w >> (16 * off[1])) & 32'hFFFF);
    case (f3)
      3'b000:  v = (b >= 128) ? b - 256 : b;
      3'b100:  v = b;
      3'b001:  v = (h >= 32768) ? h - 65536 : h;
      3'b101:  v = h;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic bit legal_model(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if ((f3 == 3'b001 || f3 == 3'b101) && off[0]) return 1'b0;
    if (f3 == 3'b010 && off != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  // Present one instruction, wait (bounded) for acceptance, update the model.
  task automatic issue(input logic [4:0] rd, input logic [31:0] res, input logic ld,
                       input logic [2:0] f3, input logic [1:0] off);
    bit ok = 1'b0;
    ev_t ev;
    @(negedge clk);
    in_rd = rd; in_result = res; in_is_load = ld; in_funct3 = f3; in_byte_off = off;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
    if (!ld) begin
      if (rd != 0) begin
        ev.is_fault = 1'b0; ev.rd = rd; ev.data = res;
        sb_q.push_back(ev);
      end
      exp_retired++;
    end else if (legal_model(f3, off)) begin
      model_pending = 1'b1; model_pend_rd = rd; model_f3 = f3; model_off = off; model_load_rd = rd;
    end else begin
      ev.is_fault = 1'b1; ev.rd = '0; ev.data = '0;
      sb_q.push_back(ev);
    end
  endtask

  // Answer a pending load after 'cycles' cycles of load_pending (cycles >= 1).
  task automatic respond(input int cycles, input logic [31:0] data, input logic err);
    ev_t ev;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("wait_pending", load_pending, 1);
      if (i == cycles - 1) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = data; mem_rsp_err = err;
      end
    end
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    model_pending = 1'b0;
    if (err) begin
      ev.is_fault = 1'b1; ev.rd = '0; ev.data = '0;
      sb_q.push_back(ev);
    end else begin
      if (model_load_rd != 0) begin
        ev.is_fault = 1'b0; ev.rd = model_load_rd; ev.data = align_model(model_f3, model_off, data);
        sb_q.push_back(ev);
      end
      exp_retired++;
    end
  endtask

  // Per-cycle compare of DUT outputs against the transaction model.
  ev_t sb_ev;
  bit  prev_we = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (write_en) begin
        check("we_gap", prev_we, 0);
        if (sb_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          sb_ev = sb_q.pop_front();
          check("sb_kind_write", sb_ev.is_fault, 0);
          check("sb_dest", write_dest, sb_ev.rd);
          check("sb_data", write_data, sb_ev.data);
        end
        check("fwd_match", {fwd_rd, fwd_data}, {write_dest, write_data});
      end
      if (load_fault) begin
        check("fault_no_write", write_en, 0);
        if (sb_q.size() == 0) check("unexpected_fault", 1, 0);
        else begin
          sb_ev = sb_q.pop_front();
          check("sb_kind_fault", sb_ev.is_fault, 1);
        end
      end
      check("fwd_valid", fwd_valid, write_en);
      check("pending", load_pending, model_pending);
      if (model_pending) check("pending_rd", load_pending_rd, model_pend_rd);
      if (in_ready && !in_valid) check("retired", retired, exp_retired);
      prev_we = write_en;
    end else begin
      prev_we = 1'b0;
    end
  end

  initial begin
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_we", write_en, 0);
    check("rst_wdata", write_data, 0);
    check("rst_retired", retired, 0);
    check("rst_pending", load_pending, 0);
    check("rst_fault", load_fault, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);

    // ALU op rd=5
    issue(5'd5, 32'h12345678, 1'b0, 3'b000, 2'd0);
    @(negedge clk);
    check("alu_we", write_en, 1);
    check("alu_dest", write_dest, 5);
    check("alu_data", write_data, 32'h12345678);
    @(negedge clk);
    check("alu_we_off", write_en, 0);
    check("alu_retired", retired, 1);

    // LB / LBU, offset 3
    issue(5'd7, 32'h0, 1'b1, 3'b000, 2'd3);
    respond(1, 32'h80FFFFFF, 1'b0);
    @(negedge clk);
    check("lb_we", write_en, 1);
    check("lb_data", write_data, 32'hFFFFFF80);
    issue(5'd8, 32'h0, 1'b1, 3'b100, 2'd3);
    respond(1, 32'h80FFFFFF, 1'b0);
    @(negedge clk);
    check("lbu_data", write_data, 32'h00000080);

    // LH offset 2, three-cycle wait
    issue(5'd10, 32'h0, 1'b1, 3'b001, 2'd2);
    respond(3, 32'h7FFF0000, 1'b0);
    @(negedge clk);
    check("lh_we", write_en, 1);
    check("lh_data", write_data, 32'h00007FFF);

    // Extra lanes: LHU low half with sign bit set, LW full word
    issue(5'd11, 32'h0, 1'b1, 3'b101, 2'd0);
    respond(2, 32'h1234F00D, 1'b0);
    issue(5'd12, 32'h0, 1'b1, 3'b010, 2'd0);
    respond(1, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("lw_data", write_data, 32'hDEADBEEF);

    // Misaligned LW: fault pulse right after accept
    issue(5'd9, 32'h0, 1'b1, 3'b010, 2'd1);
    @(negedge clk);
    check("mis_fault", load_fault, 1);
    check("mis_we", write_en, 0);
    @(negedge clk);
    check("mis_fault_end", load_fault, 0);

    // Reserved funct3 and misaligned LH
    issue(5'd9, 32'h0, 1'b1, 3'b110, 2'd0);
    issue(5'd9, 32'h0, 1'b1, 3'b001, 2'd3);

    // Bus error response
    issue(5'd9, 32'h0, 1'b1, 3'b010, 2'd0);
    respond(2, 32'h55555555, 1'b1);
    @(negedge clk);
    check("buserr_fault", load_fault, 1);
    check("buserr_we", write_en, 0);

    // Back-to-back ALU ops with in_valid held
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back('{1'b0, 5'd3, 32'h0000A5A5});
    sb_q.push_back('{1'b0, 5'd4, 32'h00005A5A});
    exp_retired += 2;
    in_rd = 5'd3; in_result = 32'h0000A5A5; in_is_load = 1'b0; in_valid = 1'b1;
    check("b2b_ready", in_ready, 1);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_we", write_en, pat[k]);
      if (k == 0) begin in_rd = 5'd4; in_result = 32'h00005A5A; end
      if (k == 2) in_valid = 1'b0;
    end
    check("b2b_data", write_data, 32'h00005A5A);

    // rd=0: no write, counter still advances
    issue(5'd0, 32'hFFFFFFFF, 1'b0, 3'b000, 2'd0);
    @(negedge clk);
    check("rd0_we", write_en, 0);
    @(negedge clk);
    check("rd0_retired", retired, exp_retired);

    // Reset while waiting on memory
    issue(5'd12, 32'h0, 1'b1, 3'b010, 2'd0);
    @(negedge clk);
    check("pre_rst_pending", load_pending_rd, 12);
    rst = 1'b0;
    model_pending = 1'b0; exp_retired = '0;
    #1;
    check("arst_pending", load_pending, 0);
    check("arst_retired", retired, 0);
    check("arst_wdata", write_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11223344;
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_rsp_we", write_en, 0);
    end
    check("late_rsp_retired", retired, 0);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
